// File: rtl/alu_seq_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_muldiv_pkg
// Brief  : Shared op-code constants and FSM state type for the sequential ALU
// Rev    : 1.0  initial release
// ============================================================================
package alu_seq_muldiv_pkg;

  // Base ALU operations, f[4]=0, selected by f[2:0]
  localparam logic [2:0] OP_ADD  = 3'd0;  // add, or sub when f[3]=1
  localparam logic [2:0] OP_SLL  = 3'd1;  // sll, sla when f[3]=1 (identical)
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;  // srl, sra when f[3]=1
  localparam logic [2:0] OP_OR   = 3'd6;  // or, nor when f[3]=1
  localparam logic [2:0] OP_AND  = 3'd7;

  // Iterative operations, f[4]=1, selected by f[2:0]
  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_MDNOP = 3'd3;  // returns 0 with single-cycle latency
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;
  localparam logic [2:0] OP_REMU  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops whose operands are treated as two's complement
  function automatic logic is_signed_md(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_muldiv_if
// Brief  : Request/response handshake bundle for the sequential ALU
// Rev    : 1.0  initial release
// ============================================================================
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  // Requester side (register-file read / writeback stages)
  modport master (
    output in_valid, a, b, f, out_ready,
    input  in_ready, out_valid, y, zero, neg, carry, ovf
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, f, out_ready,
    output in_ready, out_valid, y, zero, neg, carry, ovf
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_muldiv_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module : muldiv_iter
// Brief  : One-bit-per-cycle shift-add multiplier / restoring divider working
//          on operand magnitudes, with sign fix-up on the final iteration.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_iter
  import alu_seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  // hi:lo is the product register for multiply, remainder:quotient for divide
  logic [WIDTH-1:0] hi, lo, opd;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [2:0]       op_r;
  logic             neg_q, neg_r, b_zero;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, nxt_hi, nxt_lo;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Operand magnitudes and sign bookkeeping, evaluated at start
  always_comb begin
    sgn   = is_signed_md(op);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  // One iteration: multiply adds and shifts right, divide shifts left and trial-subtracts.
  // The divider remainder stays below the divisor, so the difference fits WIDTH bits.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opd});
    div_diff = div_sh[WIDTH-1:0] - opd;
    if (op_r[2]) begin
      nxt_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the post-iteration values so the result is ready on the last edge
  always_comb begin
    prod   = {nxt_hi, nxt_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = b_zero ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    rem_s  = neg_r ? -nxt_hi : nxt_hi;
    case (op_r)
      OP_MUL:            result = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:   result = quo_s;
      OP_REM, OP_REMU:   result = rem_s;
      default:           result = '0;
    endcase
    last = busy && (cnt == CW'(WIDTH - 1));
  end

  // Iteration state: load on start, then WIDTH shift steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (start) begin
      hi     <= '0;
      lo     <= op[2] ? mag_a : mag_b;
      opd    <= op[2] ? mag_b : mag_a;
      cnt    <= '0;
      busy   <= 1'b1;
      op_r   <= op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      b_zero <= (b == '0);
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_muldiv
// Brief  : Registered ALU with valid/ready handshake; single-cycle base ops and
//          WIDTH-iteration multiply/divide/remainder.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seq_muldiv_if.slave   bus
);
  state_t           state, state_nxt;
  logic             load_alu, load_md, md_start, md_last;
  logic [WIDTH-1:0] md_result;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] y_r;
  logic             zero_r, neg_r, carry_r, ovf_r;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (bus.f[2:0]),
    .a      (bus.a),
    .b      (bus.b),
    .last   (md_last),
    .result (md_result)
  );

  // Combinational base ALU on the request operands; the md no-op also lands here as 0
  always_comb begin
    sum   = '0;
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    shamt = bus.b[SHW-1:0];
    case (bus.f[2:0])
      OP_ADD: begin
        sum   = bus.f[3] ? ({1'b0, bus.a} - {1'b0, bus.b}) : ({1'b0, bus.a} + {1'b0, bus.b});
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = sum[WIDTH] ^ sum[WIDTH-1] ^ bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
      OP_SLL:  alu_y = bus.a << shamt;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:  alu_y = bus.a ^ bus.b;
      OP_SR:   alu_y = bus.f[3] ? WIDTH'($signed(bus.a) >>> shamt) : (bus.a >> shamt);
      OP_OR:   alu_y = bus.f[3] ? ~(bus.a | bus.b) : (bus.a | bus.b);
      default: alu_y = bus.a & bus.b;
    endcase
    if (bus.f[4]) begin
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and load strobes; draining DONE always returns to IDLE first
  always_comb begin
    state_nxt = state;
    load_alu  = 1'b0;
    load_md   = 1'b0;
    md_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.f[4] && (bus.f[2:0] != OP_MDNOP)) begin
            md_start  = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            load_alu  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_last) begin
          load_md   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result and flag register, held until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= '0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_alu) begin
      y_r     <= alu_y;
      zero_r  <= (alu_y == '0);
      neg_r   <= alu_y[WIDTH-1];
      carry_r <= alu_c;
      ovf_r   <= alu_v;
    end else if (load_md) begin
      y_r     <= md_result;
      zero_r  <= (md_result == '0);
      neg_r   <= md_result[WIDTH-1];
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.y         = y_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_seq_muldiv
// Brief  : Directed self-checking bench for alu_seq_muldiv at WIDTH 32 and 8
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_seq_muldiv;

  typedef struct packed {
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  fl;   // {zero, neg, carry, ovf}
    logic [7:0]  lat;
  } vec32_t;

  typedef struct packed {
    logic [4:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] fl;
    logic [7:0] lat;
  } vec8_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_muldiv_if #(.WIDTH(32)) bus32 ();
  alu_seq_muldiv_if #(.WIDTH(8))  bus8 ();

  alu_seq_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  alu_seq_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  // Issue one op on the 32-bit unit, scramble inputs after accept, wait for the result, drain it
  task automatic op32(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] y, output logic [3:0] fl, output int lat);
    int w = 0;
    while (!bus32.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus32.f = f; bus32.a = a; bus32.b = b; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0; bus32.a = 32'hDEADBEEF; bus32.b = 32'h0BADF00D; bus32.f = 5'b01000;
    lat = 1;
    while (!bus32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    y  = bus32.y;
    fl = {bus32.zero, bus32.neg, bus32.carry, bus32.ovf};
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [4:0] f, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] y, output logic [3:0] fl, output int lat);
    int w = 0;
    while (!bus8.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus8.f = f; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.f = 5'b01000;
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    y  = bus8.y;
    fl = {bus8.zero, bus8.neg, bus8.carry, bus8.ovf};
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b exp=1", bus32.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", bus32.out_valid); end
    checks++; if (bus32.y !== 32'h0) begin failures++; $display("FAIL reset y got=%h exp=00000000", bus32.y); end
    checks++;
    if ({bus32.zero, bus32.neg, bus32.carry, bus32.ovf} !== 4'b0000) begin
      failures++; $display("FAIL reset flags got=%b exp=0000", {bus32.zero, bus32.neg, bus32.carry, bus32.ovf});
    end
    checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset8 in_ready got=%b exp=1", bus8.in_ready); end
  endtask

  task automatic test_table32(input string name, input vec32_t v[]);
    logic [31:0] y;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < v.size(); i++) begin
      op32(v[i].f, v[i].a, v[i].b, y, fl, lat);
      checks++; if (y !== v[i].y) begin failures++; $display("FAIL %s[%0d] y got=%h exp=%h", name, i, y, v[i].y); end
      checks++; if (fl !== v[i].fl) begin failures++; $display("FAIL %s[%0d] flags got=%b exp=%b", name, i, fl, v[i].fl); end
      checks++; if (lat !== int'(v[i].lat)) begin failures++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat, v[i].lat); end
    end
  endtask

  task automatic test_alu();
    vec32_t v[];
    v = new[15];
    v[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 8'd1};
    v[1]  = '{5'b01000, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 8'd1};
    v[2]  = '{5'b01000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110, 8'd1};
    v[3]  = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 8'd1};
    v[4]  = '{5'b01101, 32'hF0000000, 32'h00000004, 32'hFF000000, 4'b0100, 8'd1};
    v[5]  = '{5'b00101, 32'hF0000000, 32'h00000004, 32'h0F000000, 4'b0000, 8'd1};
    v[6]  = '{5'b00001, 32'h00000001, 32'h00000024, 32'h00000010, 4'b0000, 8'd1};
    v[7]  = '{5'b01001, 32'h00000003, 32'h00000001, 32'h00000006, 4'b0000, 8'd1};
    v[8]  = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 8'd1};
    v[9]  = '{5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 8'd1};
    v[10] = '{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 8'd1};
    v[11] = '{5'b00110, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b0100, 8'd1};
    v[12] = '{5'b01110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 8'd1};
    v[13] = '{5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 8'd1};
    v[14] = '{5'b10011, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1000, 8'd1};
    test_table32("alu", v);
  endtask

  task automatic test_muldiv();
    vec32_t v[];
    v = new[13];
    v[0]  = '{5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 8'd33};
    v[1]  = '{5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 8'd33};
    v[2]  = '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 8'd33};
    v[3]  = '{5'b10000, 32'h00012345, 32'h00001000, 32'h12345000, 4'b0000, 8'd33};
    v[4]  = '{5'b10001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 4'b0100, 8'd33};
    v[5]  = '{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100, 8'd33};
    v[6]  = '{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 8'd33};
    v[7]  = '{5'b10101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 8'd33};
    v[8]  = '{5'b10111, 32'h00001234, 32'h00000000, 32'h00001234, 4'b0000, 8'd33};
    v[9]  = '{5'b10100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 8'd33};
    v[10] = '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 8'd33};
    v[11] = '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 8'd33};
    v[12] = '{5'b10111, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 8'd33};
    test_table32("muldiv", v);
  endtask

  task automatic test_backpressure();
    int w = 0;
    while (!bus32.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus32.f = 5'b00000; bus32.a = 32'd3; bus32.b = 32'd4; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.a = 32'd10; bus32.b = 32'd20;   // second request waits behind the first
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus32.out_valid !== 1'b1) begin failures++; $display("FAIL bp[%0d] out_valid got=%b exp=1", i, bus32.out_valid); end
      checks++; if (bus32.y !== 32'd7) begin failures++; $display("FAIL bp[%0d] y got=%h exp=00000007", i, bus32.y); end
      checks++; if (bus32.in_ready !== 1'b0) begin failures++; $display("FAIL bp[%0d] in_ready got=%b exp=0", i, bus32.in_ready); end
      @(posedge clk); #1;
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL bp drain out_valid got=%b exp=0", bus32.out_valid); end
    checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL bp drain in_ready got=%b exp=1", bus32.in_ready); end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++; if (bus32.out_valid !== 1'b1) begin failures++; $display("FAIL bp second out_valid got=%b exp=1", bus32.out_valid); end
    checks++; if (bus32.y !== 32'd30) begin failures++; $display("FAIL bp second y got=%h exp=0000001e", bus32.y); end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] y;
    logic [3:0]  fl;
    int          lat;
    int          w = 0;
    while (!bus32.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus32.f = 5'b10101; bus32.a = 32'd100; bus32.b = 32'd7; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid in_ready got=%b exp=1", bus32.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid out_valid got=%b exp=0", bus32.out_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid stale out_valid got=%b exp=0", bus32.out_valid); end
    checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid post in_ready got=%b exp=1", bus32.in_ready); end
    op32(5'b10101, 32'd100, 32'd7, y, fl, lat);
    checks++; if (y !== 32'h0000000E) begin failures++; $display("FAIL rstmid divu y got=%h exp=0000000e", y); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL rstmid divu latency got=%0d exp=33", lat); end
  endtask

  task automatic test_width8();
    vec8_t v[5];
    logic [7:0] y;
    logic [3:0] fl;
    int         lat;
    v[0] = '{5'b00000, 8'h7F, 8'h01, 8'h80, 4'b0101, 8'd1};
    v[1] = '{5'b10000, 8'hFF, 8'hFF, 8'h01, 4'b0000, 8'd9};
    v[2] = '{5'b10010, 8'hFF, 8'hFF, 8'hFE, 4'b0100, 8'd9};
    v[3] = '{5'b10001, 8'hFF, 8'hFF, 8'h00, 4'b1000, 8'd9};
    v[4] = '{5'b10100, 8'h80, 8'hFF, 8'h80, 4'b0100, 8'd9};
    for (int i = 0; i < 5; i++) begin
      op8(v[i].f, v[i].a, v[i].b, y, fl, lat);
      checks++; if (y !== v[i].y) begin failures++; $display("FAIL w8[%0d] y got=%h exp=%h", i, y, v[i].y); end
      checks++; if (fl !== v[i].fl) begin failures++; $display("FAIL w8[%0d] flags got=%b exp=%b", i, fl, v[i].fl); end
      checks++; if (lat !== int'(v[i].lat)) begin failures++; $display("FAIL w8[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = '0; bus32.b = '0; bus32.f = '0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.f  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_muldiv();
    test_backpressure();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
